// File: rtl/feature_binarizer_pkg.sv
// Shared widths, payload types and control states for the feature binarizer.
package feature_binarizer_pkg;

  localparam int unsigned N_MEL        = 32;
  localparam int unsigned BIT_WIDTH    = 16;
  localparam int unsigned N_TH_M       = 4;
  localparam int unsigned N_TH_F       = 4;
  localparam int unsigned RD_LAT       = 2;
  localparam int unsigned FEAT_PER_BIN = N_TH_M + N_TH_F;
  localparam int unsigned FW           = FEAT_PER_BIN * N_MEL;
  localparam int unsigned CFG_ADDR_W   = 3;
  localparam int unsigned FIDX_W       = 8;
  localparam int unsigned CNT_W        = $clog2(N_MEL + 1);
  localparam int unsigned SLOT_W       = $clog2(N_MEL);

  typedef logic [BIT_WIDTH-1:0] sample_t;

  // Threshold bank: mfcc thresholds in the low entries, flux above them.
  typedef sample_t [FEAT_PER_BIN-1:0] thr_bank_t;

  typedef struct packed {
    logic [N_TH_F-1:0] f;
    logic [N_TH_M-1:0] m;
  } bin_t;

  typedef enum logic [1:0] {FB_FILL, FB_XFER, FB_HOLD} fb_state_t;

endpackage

// File: rtl/feature_binarizer_if.sv
// Bin input stream and frame output stream of the feature binarizer.
interface feature_binarizer_if;
  import feature_binarizer_pkg::*;

  logic              mel_valid;
  sample_t           mfcc_data;
  sample_t           flux_data;
  logic              mel_ready;
  logic              feat_valid;
  logic              feat_ready;
  logic [FW-1:0]     feat_data;
  logic [FIDX_W-1:0] frame_idx;

  modport master (
    output mel_valid, mfcc_data, flux_data, feat_ready,
    input  mel_ready, feat_valid, feat_data, frame_idx
  );

  modport slave (
    input  mel_valid, mfcc_data, flux_data, feat_ready,
    output mel_ready, feat_valid, feat_data, frame_idx
  );

endinterface

// File: rtl/feature_binarizer_thermo_encoder.sv
// Thermometer code: bit k set when value is strictly above threshold k (unsigned).
module feature_binarizer_thermo_encoder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]        value_i,
  input  logic [N-1:0][W-1:0] thr_i,
  output logic [N-1:0]        code_c_o
);

  always_comb begin
    code_c_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      code_c_o[k] = (value_i > thr_i[k]);
    end
  end

endmodule

// File: rtl/feature_binarizer.sv
// Encodes mel bins against global thresholds and assembles them into
// frame vectors handed downstream with valid/ready.
module feature_binarizer
  import feature_binarizer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_en_inf_system_sync,
  input  logic                  cfg_we,
  input  logic [CFG_ADDR_W-1:0] cfg_addr,
  input  sample_t               cfg_wdata,
  feature_binarizer_if.slave    bus,
  output logic                  overflow_err
);

  fb_state_t         state_q, state_d;
  logic [CNT_W-1:0]  asm_cnt_q, asm_cnt_d, cnt_base_c;
  bin_t [N_MEL-1:0]  asm_vec_q, asm_vec_d;
  logic [FW-1:0]     feat_data_q, feat_data_d;
  logic              out_full_q, out_full_d;
  logic [FIDX_W-1:0] frame_idx_q, frame_idx_d;
  logic              ovf_q, ovf_d;
  logic              mel_ready_q, mel_ready_d;
  thr_bank_t         thr_q, thr_d;

  logic [N_TH_M-1:0] m_code_c;
  logic [N_TH_F-1:0] f_code_c;
  bin_t              bin_c;
  logic              xfer_c;
  logic              handshake_c;

  feature_binarizer_thermo_encoder #(.N(N_TH_M), .W(BIT_WIDTH)) u_enc_mfcc (
    .value_i  (bus.mfcc_data),
    .thr_i    (thr_q[N_TH_M-1:0]),
    .code_c_o (m_code_c)
  );

  feature_binarizer_thermo_encoder #(.N(N_TH_F), .W(BIT_WIDTH)) u_enc_flux (
    .value_i  (bus.flux_data),
    .thr_i    (thr_q[FEAT_PER_BIN-1:N_TH_M]),
    .code_c_o (f_code_c)
  );

  assign bin_c = {f_code_c, m_code_c};

  // Next-state: transfer a complete frame when the output slot is free or draining this cycle.
  always_comb begin
    state_d     = state_q;
    asm_cnt_d   = asm_cnt_q;
    asm_vec_d   = asm_vec_q;
    feat_data_d = feat_data_q;
    out_full_d  = out_full_q;
    frame_idx_d = frame_idx_q;
    ovf_d       = ovf_q;
    thr_d       = thr_q;
    mel_ready_d = mel_ready_q;

    xfer_c      = (state_q == FB_XFER) || ((state_q == FB_HOLD) && bus.feat_ready);
    handshake_c = out_full_q && bus.feat_ready;
    cnt_base_c  = xfer_c ? '0 : asm_cnt_q;

    if (cfg_we) begin
      for (int unsigned k = 0; k < FEAT_PER_BIN; k++) begin
        if (cfg_addr == CFG_ADDR_W'(k)) thr_d[CFG_ADDR_W'(k)] = cfg_wdata;
      end
    end

    if (!spi_en_inf_system_sync) begin
      asm_cnt_d   = '0;
      asm_vec_d   = '0;
      feat_data_d = '0;
      out_full_d  = 1'b0;
      frame_idx_d = '0;
      ovf_d       = 1'b0;
    end else begin
      asm_cnt_d = cnt_base_c;
      if (xfer_c) begin
        feat_data_d = asm_vec_q;
        out_full_d  = 1'b1;
      end else if (handshake_c) begin
        out_full_d  = 1'b0;
      end
      if (handshake_c) frame_idx_d = frame_idx_q + FIDX_W'(1);
      if (bus.mel_valid) begin
        if (cnt_base_c < CNT_W'(N_MEL)) begin
          asm_vec_d[cnt_base_c[SLOT_W-1:0]] = bin_c;
          asm_cnt_d = cnt_base_c + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    if (asm_cnt_d == CNT_W'(N_MEL)) state_d = out_full_d ? FB_HOLD : FB_XFER;
    else                            state_d = FB_FILL;

    // Leave room for the reads upstream has already issued.
    mel_ready_d = !(out_full_d && (asm_cnt_d >= CNT_W'(N_MEL - RD_LAT)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FB_FILL;
      asm_cnt_q   <= '0;
      asm_vec_q   <= '0;
      feat_data_q <= '0;
      out_full_q  <= 1'b0;
      frame_idx_q <= '0;
      ovf_q       <= 1'b0;
      mel_ready_q <= 1'b1;
      thr_q       <= '0;
    end else begin
      state_q     <= state_d;
      asm_cnt_q   <= asm_cnt_d;
      asm_vec_q   <= asm_vec_d;
      feat_data_q <= feat_data_d;
      out_full_q  <= out_full_d;
      frame_idx_q <= frame_idx_d;
      ovf_q       <= ovf_d;
      mel_ready_q <= mel_ready_d;
      thr_q       <= thr_d;
    end
  end

  assign bus.mel_ready  = mel_ready_q;
  assign bus.feat_valid = out_full_q;
  assign bus.feat_data  = feat_data_q;
  assign bus.frame_idx  = frame_idx_q;
  assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_feature_binarizer.sv
// Bench for feature_binarizer: random bins checked against a frame-level reference model.
module tb_feature_binarizer;
  import feature_binarizer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  spi_en;
  logic                  cfg_we;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  sample_t               cfg_wdata;
  logic                  overflow_err;

  feature_binarizer_if bus();

  feature_binarizer dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .spi_en_inf_system_sync (spi_en),
    .cfg_we                 (cfg_we),
    .cfg_addr               (cfg_addr),
    .cfg_wdata              (cfg_wdata),
    .bus                    (bus),
    .overflow_err           (overflow_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: thresholds, partial frame, completed frames in order.
  int unsigned   thr_model [FEAT_PER_BIN];
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] acc;
  int            acc_cnt;
  int            exp_idx;
  bit            drop_next;
  bit [RD_LAT-1:0] pipe;
  bit            up_want;

  function automatic logic [FEAT_PER_BIN-1:0] encode(input int unsigned m, input int unsigned f);
    logic [FEAT_PER_BIN-1:0] r;
    for (int k = 0; k < N_TH_M; k++) r[k] = (m > thr_model[k]);
    for (int k = 0; k < N_TH_F; k++) r[N_TH_M+k] = (f > thr_model[N_TH_M+k]);
    return r;
  endfunction

  task automatic model_clear();
    acc = '0;
    acc_cnt = 0;
    exp_q.delete();
    exp_idx = 0;
  endtask

  task automatic model_push(input int unsigned m, input int unsigned f);
    acc[acc_cnt*FEAT_PER_BIN +: FEAT_PER_BIN] = encode(m, f);
    acc_cnt++;
    if (acc_cnt == N_MEL) begin
      exp_q.push_back(acc);
      acc = '0;
      acc_cnt = 0;
    end
  endtask

  // One clock: account for what the coming edge samples, then step past it.
  task automatic tick();
    logic [FW-1:0] ef;
    if (rst_n && spi_en) begin
      if (bus.feat_valid && bus.feat_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL frame_unexpected: got idx=%0d, no frame was due", bus.frame_idx);
        end else begin
          ef = exp_q.pop_front();
          if (bus.feat_data !== ef || bus.frame_idx !== 8'(exp_idx)) begin
            bad++;
            $display("FAIL frame_data: got idx=%0d data=%h, need idx=%0d data=%h",
                     bus.frame_idx, bus.feat_data, 8'(exp_idx), ef);
          end
        end
        exp_idx = (exp_idx + 1) % 256;
      end
      if (bus.mel_valid) begin
        if (drop_next) drop_next = 1'b0;
        else model_push(bus.mfcc_data, bus.flux_data);
      end
    end
    if (!rst_n) begin
      model_clear();
      foreach (thr_model[k]) thr_model[k] = 0;
    end else begin
      if (cfg_we) thr_model[cfg_addr] = cfg_wdata;
      if (!spi_en) model_clear();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed_bin(input int unsigned m, input int unsigned f);
    bus.mel_valid = 1'b1;
    bus.mfcc_data = 16'(m);
    bus.flux_data = 16'(f);
    tick();
    bus.mel_valid = 1'b0;
  endtask

  task automatic feed_random(input int n);
    for (int i = 0; i < n; i++) feed_bin($urandom_range(0, 500), $urandom_range(0, 50));
  endtask

  task automatic set_thr(input int unsigned a, input int unsigned v);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_wdata = 16'(v);
  endtask

  task automatic write_thr(input int unsigned a, input int unsigned v);
    set_thr(a, v);
    tick();
    cfg_we = 1'b0;
  endtask

  // Upstream with RD_LAT read latency: issue on sampled mel_ready, data arrives later.
  task automatic stream_cycle();
    bus.mel_valid = pipe[RD_LAT-1];
    if (pipe[RD_LAT-1]) begin
      bus.mfcc_data = 16'($urandom_range(0, 500));
      bus.flux_data = 16'($urandom_range(0, 50));
    end
    pipe = {pipe[RD_LAT-2:0], (up_want && bus.mel_ready)};
    tick();
    bus.mel_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spi_en = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    bus.mel_valid = 1'b0; bus.mfcc_data = '0; bus.flux_data = '0; bus.feat_ready = 1'b0;
    drop_next = 1'b0; pipe = '0; up_want = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    total++; if (bus.feat_valid !== 1'b0) begin bad++; $display("FAIL reset_feat_valid: got %b need 0", bus.feat_valid); end
    total++; if (bus.feat_data !== '0) begin bad++; $display("FAIL reset_feat_data: got %h need 0", bus.feat_data); end
    total++; if (bus.frame_idx !== 8'd0) begin bad++; $display("FAIL reset_frame_idx: got %0d need 0", bus.frame_idx); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b need 0", overflow_err); end
    total++; if (bus.mel_ready !== 1'b1) begin bad++; $display("FAIL reset_mel_ready: got %b need 1", bus.mel_ready); end
  endtask

  task automatic test_encode_frame();
    logic [FW-1:0] fv;
    logic [7:0]    exp_b [6];
    exp_b = '{8'h73, 8'h00, 8'hff, 8'h0f, 8'h01, 8'h00};
    for (int k = 0; k < FEAT_PER_BIN; k++) write_thr(k, (k < N_TH_M) ? 100*(k+1) : 10*(k-N_TH_M+1));
    bus.feat_ready = 1'b1;
    feed_bin(250, 35);
    feed_bin(100, 10);
    feed_bin(401, 41);
    feed_bin(65535, 0);
    set_thr(0, 200); feed_bin(150, 0);
    set_thr(0, 100); feed_bin(150, 0);
    cfg_we = 1'b0;
    feed_random(N_MEL - 6);
    total++; if (bus.feat_valid !== 1'b0) begin bad++; $display("FAIL latency_early: got feat_valid=%b need 0", bus.feat_valid); end
    tick();
    total++; if (bus.feat_valid !== 1'b1) begin bad++; $display("FAIL latency_2cyc: got feat_valid=%b need 1", bus.feat_valid); end
    total++; if (bus.frame_idx !== 8'd0) begin bad++; $display("FAIL first_idx: got %0d need 0", bus.frame_idx); end
    fv = bus.feat_data;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (fv[i*8 +: 8] !== exp_b[i]) begin
        bad++; $display("FAIL bin_field%0d: got %h need %h", i, fv[i*8 +: 8], exp_b[i]);
      end
    end
    tick();
    total++; if (bus.frame_idx !== 8'd1) begin bad++; $display("FAIL idx_advance: got %0d need 1", bus.frame_idx); end
    total++; if (bus.feat_valid !== 1'b0) begin bad++; $display("FAIL valid_drop: got %b need 0", bus.feat_valid); end
  endtask

  task automatic test_back_to_back();
    bit saw_drop;
    spi_en = 1'b0; tick(); spi_en = 1'b1;
    bus.feat_ready = 1'b0; up_want = 1'b1; pipe = '0; saw_drop = 1'b0;
    for (int c = 0; c < 100; c++) begin
      stream_cycle();
      if (!saw_drop && !bus.mel_ready) begin
        saw_drop = 1'b1;
        total++;
        if (acc_cnt != N_MEL - RD_LAT || exp_q.size() != 1) begin
          bad++; $display("FAIL ready_drop_point: dropped at bin %0d with %0d frames pending, need bin %0d with 1",
                          acc_cnt, exp_q.size(), N_MEL - RD_LAT);
        end
      end
    end
    total++; if (!saw_drop) begin bad++; $display("FAIL stall_ready: got mel_ready never low, need low"); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL stall_overflow: got %b need 0", overflow_err); end
    total++; if (bus.feat_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b need 1", bus.feat_valid); end
    bus.feat_ready = 1'b1;
    stream_cycle();
    total++;
    if (bus.feat_valid !== 1'b1 || bus.frame_idx !== 8'(exp_idx)) begin
      bad++; $display("FAIL release_no_bubble: got valid=%b idx=%0d need valid=1 idx=%0d",
                      bus.feat_valid, bus.frame_idx, 8'(exp_idx));
    end
    for (int c = 0; c < 150; c++) stream_cycle();
    up_want = 1'b0;
    for (int c = 0; c < RD_LAT + 2; c++) stream_cycle();
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL stream_overflow: got %b need 0", overflow_err); end
  endtask

  task automatic test_overflow();
    spi_en = 1'b0; tick(); spi_en = 1'b1;
    bus.feat_ready = 1'b0;
    feed_random(N_MEL); tick();
    feed_random(N_MEL); tick();
    total++; if (bus.mel_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b need 0", bus.mel_ready); end
    drop_next = 1'b1;
    feed_bin(123, 45);
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b need 1", overflow_err); end
    total++;
    if (exp_q.size() == 0 || bus.feat_data !== exp_q[0]) begin
      bad++; $display("FAIL overflow_data_held: got %h, held frame changed or missing", bus.feat_data);
    end
    tick();
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b need 1", overflow_err); end
    spi_en = 1'b0; tick(); spi_en = 1'b1;
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL overflow_clear: got %b need 0", overflow_err); end
    total++; if (bus.feat_valid !== 1'b0) begin bad++; $display("FAIL disable_valid: got %b need 0", bus.feat_valid); end
    total++; if (bus.mel_ready !== 1'b1) begin bad++; $display("FAIL disable_ready: got %b need 1", bus.mel_ready); end
  endtask

  task automatic test_disable_mid();
    bus.feat_ready = 1'b1;
    feed_random(N_MEL); tick(); tick();
    total++; if (bus.frame_idx !== 8'(exp_idx)) begin bad++; $display("FAIL pre_disable_idx: got %0d need %0d", bus.frame_idx, 8'(exp_idx)); end
    feed_random(17);
    spi_en = 1'b0; tick(); spi_en = 1'b1;
    total++; if (bus.frame_idx !== 8'd0) begin bad++; $display("FAIL disable_idx: got %0d need 0", bus.frame_idx); end
    total++; if (bus.feat_valid !== 1'b0) begin bad++; $display("FAIL disable_mid_valid: got %b need 0", bus.feat_valid); end
    feed_bin(250, 35);
    feed_random(N_MEL - 1);
    tick();
    total++; if (bus.feat_valid !== 1'b1) begin bad++; $display("FAIL reenable_valid: got %b need 1", bus.feat_valid); end
    total++; if (bus.feat_data[7:0] !== 8'h73) begin bad++; $display("FAIL thr_retained: got %h need 73", bus.feat_data[7:0]); end
    tick();
  endtask

  task automatic test_rst_mid();
    bus.feat_ready = 1'b0;
    feed_random(N_MEL); tick(); feed_random(5);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    total++; if (bus.feat_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b need 0", bus.feat_valid); end
    total++; if (bus.feat_data !== '0) begin bad++; $display("FAIL rst_mid_data: got %h need 0", bus.feat_data); end
    total++; if (bus.mel_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b need 1", bus.mel_ready); end
    for (int k = 0; k < N_TH_M; k++) write_thr(k, 1000*(k+1));
    for (int k = 0; k < N_TH_F; k++) write_thr(N_TH_M + k, 7 + k);
    bus.feat_ready = 1'b1;
    feed_bin(1000, 7);
    feed_bin(1001, 8);
    feed_random(N_MEL - 2);
    tick();
    total++; if (bus.feat_data[7:0] !== 8'h00) begin bad++; $display("FAIL boundary_equal: got %h need 00", bus.feat_data[7:0]); end
    total++; if (bus.feat_data[15:8] !== 8'h11) begin bad++; $display("FAIL boundary_above: got %h need 11", bus.feat_data[15:8]); end
    tick();
  endtask

  initial begin
    test_reset();
    test_encode_frame();
    test_back_to_back();
    test_overflow();
    test_disable_mid();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
